// File: rtl/ifetch_1.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM and queues {instr, pc} for decode.
// Optional macro IFETCH_BYPASS_EN forwards ROM data straight to decode when the queue is empty.
module ifetch_1 #(
  parameter int PC_W     = 10,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] pc_read_c0,
  input  logic [31:0]     instr_reg_c1,
  input  logic            redirect_c0,
  input  logic [PC_W-1:0] redirect_pc_c0,
  output logic            ifq_valid,
  output logic [31:0]     ifq_instr,
  output logic [PC_W-1:0] ifq_pc,
  input  logic            ifq_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_q;
  logic             pend_q;
  logic [PC_W-1:0]  pend_pc_q;
  logic [31:0]      q_instr [DEPTH];
  logic [PC_W-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [PC_W-1:0]  redirect_addr;
  logic             pop;
  logic             pop_q;
  logic             push;
  logic             issue;
  logic             bypass;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect_addr = {redirect_pc_c0[PC_W-1:2], 2'b00};
  assign pc_read_c0    = redirect_c0 ? redirect_addr : pc_q;

`ifdef IFETCH_BYPASS_EN
  // Empty queue with a read landing now: hand the ROM word to decode directly.
  assign bypass    = (count_q == '0) & pend_q & ~redirect_c0;
  assign ifq_valid = bypass | (count_q != '0);
  assign ifq_instr = bypass ? instr_reg_c1 : q_instr[head_q];
  assign ifq_pc    = bypass ? pend_pc_q : q_pc[head_q];
`else
  assign bypass    = 1'b0;
  assign ifq_valid = (count_q != '0);
  assign ifq_instr = q_instr[head_q];
  assign ifq_pc    = q_pc[head_q];
`endif

  assign pop   = ifq_valid & ifq_ready;
  assign pop_q = pop & ~bypass;
  assign push  = pend_q & ~redirect_c0 & ~(bypass & pop);

  // Slots that will be occupied once everything in flight lands.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(pend_q) - (CNT_W+1)'(pop);
  assign issue     = redirect_c0 | (occupancy < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= PC_W'(RESET_PC);
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (issue) begin
      pend_q    <= 1'b1;
      pend_pc_q <= pc_read_c0;
      pc_q      <= pc_read_c0 + PC_W'(4);
    end else begin
      pend_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect_c0) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  tail_q <= ptr_inc(tail_q);
      if (pop_q) head_q <= ptr_inc(head_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[tail_q] <= instr_reg_c1;
      q_pc[tail_q]    <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_1.sv
// Randomized bench for ifetch_1: ROM model plus an in-order stream model of expected fetch addresses.
module tb_ifetch_1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [9:0]  pc_read_c0;
  logic [31:0] instr_reg_c1;
  logic        redirect_c0;
  logic [9:0]  redirect_pc_c0;
  logic        ifq_valid;
  logic [31:0] ifq_instr;
  logic [9:0]  ifq_pc;
  logic        ifq_ready;

  logic [9:0]  pc_read_b;
  logic [31:0] instr_reg_b;
  logic        redirect_b = 1'b0;
  logic [9:0]  redirect_pc_b = 10'h0;
  logic        ifq_valid_b;
  logic [31:0] ifq_instr_b;
  logic [9:0]  ifq_pc_b;
  logic        ifq_ready_b = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_1 dut (
    .clk(clk), .reset_n(reset_n), .pc_read_c0(pc_read_c0), .instr_reg_c1(instr_reg_c1),
    .redirect_c0(redirect_c0), .redirect_pc_c0(redirect_pc_c0), .ifq_valid(ifq_valid),
    .ifq_instr(ifq_instr), .ifq_pc(ifq_pc), .ifq_ready(ifq_ready)
  );

  ifetch_1 #(.RESET_PC('h3F8)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .pc_read_c0(pc_read_b), .instr_reg_c1(instr_reg_b),
    .redirect_c0(redirect_b), .redirect_pc_c0(redirect_pc_b), .ifq_valid(ifq_valid_b),
    .ifq_instr(ifq_instr_b), .ifq_pc(ifq_pc_b), .ifq_ready(ifq_ready_b)
  );

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {8'hA5, 14'd0, a};
  endfunction

  always @(posedge clk) begin
    instr_reg_c1 <= rom_word(pc_read_c0);
    instr_reg_b  <= rom_word(pc_read_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream model: after reset or a redirect the accepted addresses run target, target+4, ...
  logic [9:0] exp_pc = 10'h000;
  int         idle = 0;
  bit         redir_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc     = 10'h000;
      idle       = 0;
      redir_prev = 1'b0;
    end else begin
      if (redir_prev) check_eq("valid_after_redirect", ifq_valid, 1'b0);
      if (idle >= 2)  check_eq("fetch_latency", ifq_valid, 1'b1);
      if (ifq_valid) begin
        check_eq("ifq_pc", ifq_pc, exp_pc);
        check_eq("ifq_instr", ifq_instr, rom_word(exp_pc));
      end
      if (ifq_valid && ifq_ready) exp_pc = exp_pc + 10'd4;
      if (redirect_c0) begin
        exp_pc     = {redirect_pc_c0[9:2], 2'b00};
        idle       = 1;
        redir_prev = 1'b1;
      end else begin
        redir_prev = 1'b0;
        idle       = ifq_valid ? 0 : idle + 1;
      end
    end
  end

  logic [9:0] wrap_seq [4] = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
  int         n_wrap = 0;

  always @(negedge clk) begin
    if (!reset_n) n_wrap = 0;
    else if (ifq_valid_b && n_wrap < 4) begin
      check_eq("wrap_pc", ifq_pc_b, wrap_seq[n_wrap]);
      n_wrap++;
    end
  end

  initial begin
    reset_n        = 1'b0;
    ifq_ready      = 1'b1;
    redirect_c0    = 1'b0;
    redirect_pc_c0 = 10'h0;
    repeat (3) step();
    @(negedge clk);
    check_eq("reset_valid", ifq_valid, 1'b0);
    check_eq("reset_pc", ifq_pc, 10'h0);
    check_eq("reset_instr", ifq_instr, 32'h0);
    check_eq("reset_pc_read", pc_read_c0, 10'h0);
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("pc_read_seq", pc_read_c0, 32'(4 * i));
      if (i >= 2) check_eq("stream_valid", ifq_valid, 1'b1);
      step();
    end

    ifq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", ifq_valid, 1'b1);
      check_eq("hold_pc", ifq_pc, 10'h00C);
      step();
    end
    @(negedge clk);
    check_eq("hold_pc_read", pc_read_c0, 10'h014);
    step();
    ifq_ready = 1'b1;
    repeat (4) step();

    ifq_ready = 1'b0;
    step();
    redirect_c0    = 1'b1;
    redirect_pc_c0 = 10'h123;
    ifq_ready      = 1'b1;
    @(negedge clk);
    check_eq("redirect_pc_read", pc_read_c0, 10'h120);
    step();
    redirect_c0 = 1'b0;
    @(negedge clk);
    check_eq("redirect_bubble", ifq_valid, 1'b0);
    step();
    @(negedge clk);
    check_eq("redirect_target_valid", ifq_valid, 1'b1);
    check_eq("redirect_target_pc", ifq_pc, 10'h120);
    step();

    repeat (3000) begin
      ifq_ready      = ($urandom % 4) != 0;
      redirect_c0    = ($urandom % 32) == 0;
      redirect_pc_c0 = 10'($urandom);
      step();
    end

    redirect_c0 = 1'b0;
    ifq_ready   = 1'b0;
    repeat (4) step();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_reset_valid", ifq_valid, 1'b0);
    check_eq("async_reset_pc", ifq_pc, 10'h0);
    check_eq("async_reset_instr", ifq_instr, 32'h0);
    check_eq("async_reset_pc_read", pc_read_c0, 10'h0);
    repeat (2) step();
    reset_n   = 1'b1;
    ifq_ready = 1'b1;
    @(negedge clk);
    check_eq("restart_pc_read", pc_read_c0, 10'h000);
    step();
    @(negedge clk);
    check_eq("restart_pc_read_next", pc_read_c0, 10'h004);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
